// File: rtl/ravenoc_route_engine.sv
// Per-input-port route engine: XY/YX head decode, per-VC wormhole lock, framing/range checks, saturating error count.
// Zero-latency request; state commits only on valid & ready, so backpressure holds the request and the lock state.
module ravenoc_route_engine #(
  parameter int NUM_VC      = 3,
  parameter int X_W         = 2,
  parameter int Y_W         = 2,
  parameter int ROUTER_X_ID = 0,
  parameter int ROUTER_Y_ID = 0,
  parameter int MAX_X       = 3,
  parameter int MAX_Y       = 3,
  parameter int ERR_CNT_W   = 8,
  parameter int VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 flit_valid_i,
  input  logic                 flit_ready_i,
  input  logic [1:0]           flit_type_i,
  input  logic [VC_W-1:0]      flit_vc_i,
  input  logic [X_W-1:0]       x_dest_i,
  input  logic [Y_W-1:0]       y_dest_i,
  input  logic                 alg_yx_i,
  output logic [4:0]           port_req_o,
  output logic [NUM_VC-1:0]    vc_busy_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 err_clr_i
);

  localparam logic [1:0] T_HEAD = 2'd0, T_BODY = 2'd1, T_TAIL = 2'd2, T_HEAD_TAIL = 2'd3;
  localparam logic [2:0] R_N = 3'd0, R_S = 3'd1, R_W = 3'd2, R_E = 3'd3, R_L = 3'd4;
  localparam logic [X_W-1:0] RX = X_W'(ROUTER_X_ID);
  localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y_ID);

  logic [NUM_VC-1:0]    busy_q;
  logic [2:0]           route_q [NUM_VC];
  logic [ERR_CNT_W-1:0] cnt_q;

  logic       vc_ok, is_head, dest_ok, cur_busy, fire, err_cond;
  logic [2:0] cur_route, new_route;

  assign vc_ok   = 32'(flit_vc_i) < NUM_VC;
  assign is_head = (flit_type_i == T_HEAD) || (flit_type_i == T_HEAD_TAIL);
  assign dest_ok = (32'(x_dest_i) <= MAX_X) && (32'(y_dest_i) <= MAX_Y);
  assign fire    = flit_valid_i && flit_ready_i;

  always_comb begin
    cur_busy  = 1'b0;
    cur_route = R_N;
    for (int i = 0; i < NUM_VC; i++) begin
      if (vc_ok && flit_vc_i == VC_W'(i)) begin
        cur_busy  = busy_q[i];
        cur_route = route_q[i];
      end
    end
  end

  always_comb begin
    new_route = R_L;
    if (x_dest_i == RX && y_dest_i == RY) new_route = R_L;
    else if (!alg_yx_i) begin
      if (x_dest_i != RX) new_route = (x_dest_i > RX) ? R_S : R_N;
      else                new_route = (y_dest_i < RY) ? R_W : R_E;
    end else begin
      if (y_dest_i != RY) new_route = (y_dest_i > RY) ? R_E : R_W;
      else                new_route = (x_dest_i < RX) ? R_N : R_S;
    end
  end

  // A head arriving on a locked VC is still routed; it is only flagged.
  assign err_cond = !vc_ok || (is_head ? (cur_busy || !dest_ok) : !cur_busy);
  assign err_o    = fire && err_cond;

  always_comb begin
    port_req_o = 5'b0;
    if (flit_valid_i && vc_ok) begin
      if (is_head) begin
        if (dest_ok) port_req_o = 5'b1 << new_route;
      end else if (cur_busy) begin
        port_req_o = 5'b1 << cur_route;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NUM_VC; i++) route_q[i] <= R_N;
    end else begin
      if (fire && vc_ok) begin
        for (int i = 0; i < NUM_VC; i++) begin
          if (flit_vc_i == VC_W'(i)) begin
            if (is_head) begin
              if (dest_ok && flit_type_i == T_HEAD) begin
                busy_q[i]  <= 1'b1;
                route_q[i] <= new_route;
              end else begin
                busy_q[i] <= 1'b0;
              end
            end else if (flit_type_i == T_TAIL && busy_q[i]) begin
              busy_q[i] <= 1'b0;
            end
          end
        end
      end
      if (err_clr_i)                cnt_q <= '0;
      else if (err_o && !(&cnt_q))  cnt_q <= cnt_q + 1'b1;
    end
  end

  assign vc_busy_o = busy_q;
  assign err_cnt_o = cnt_q;

  logic unused_body;
  assign unused_body = (flit_type_i == T_BODY);

endmodule

// File: tb/tb_ravenoc_route_engine.sv
// Bench for ravenoc_route_engine at router (1,1) in a 4x4 mesh with 3-bit coordinates and a 2-bit error counter.
module tb_ravenoc_route_engine;
  localparam int RXI = 1, RYI = 1, MXI = 3, MYI = 3, NVC = 3, CMAX = 3;

  logic       clk = 1'b0, arst = 1'b1;
  logic       valid = 0, ready = 0, yx = 0, clr = 0;
  logic [1:0] ftype = 0, vc = 0;
  logic [2:0] xd = 0, yd = 0;
  logic [4:0] req;
  logic [2:0] busy;
  logic       err;
  logic [1:0] cnt;

  int errors = 0, checks = 0;

  ravenoc_route_engine #(
    .NUM_VC(NVC), .X_W(3), .Y_W(3), .ROUTER_X_ID(RXI), .ROUTER_Y_ID(RYI),
    .MAX_X(MXI), .MAX_Y(MYI), .ERR_CNT_W(2)
  ) dut (
    .clk(clk), .arst(arst), .flit_valid_i(valid), .flit_ready_i(ready),
    .flit_type_i(ftype), .flit_vc_i(vc), .x_dest_i(xd), .y_dest_i(yd),
    .alg_yx_i(yx), .port_req_o(req), .vc_busy_o(busy), .err_o(err),
    .err_cnt_o(cnt), .err_clr_i(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, r; logic [1:0] t, vc; logic [2:0] x, y; logic yx, clr;
    logic [4:0] req; logic err; logic [2:0] busy; logic [1:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic r, logic [1:0] t, logic [1:0] c, logic [2:0] x, logic [2:0] y,
                              logic a, logic cl, logic [4:0] rq, logic e, logic [2:0] b, logic [1:0] n);
    vec_t s;
    s.v = v; s.r = r; s.t = t; s.vc = c; s.x = x; s.y = y; s.yx = a; s.clr = cl;
    s.req = rq; s.err = e; s.busy = b; s.cnt = n;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic [1:0] t, input logic [1:0] c,
                       input logic [2:0] x, input logic [2:0] y, input logic a, input logic cl);
    valid = v; ready = r; ftype = t; vc = c; xd = x; yd = y; yx = a; clr = cl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
  endtask

  // Reference model: per-VC lock flag and stored output port number (0 N, 1 S, 2 W, 3 E, 4 LOCAL).
  bit m_busy[4];
  int m_port[4];
  int m_cnt;

  function automatic int route(int x, int y, bit a);
    if (x == RXI && y == RYI) return 4;
    if (!a) return (x != RXI) ? ((x > RXI) ? 1 : 0) : ((y < RYI) ? 2 : 3);
    return (y != RYI) ? ((y > RYI) ? 3 : 2) : ((x < RXI) ? 0 : 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_busy[i] = 0; m_port[i] = 0; end
    m_cnt = 0;
  endtask

  task automatic model_eval(output int exp_req, output int exp_err);
    bit head, in_range, bad;
    head = (ftype == 0) || (ftype == 3);
    in_range = (xd <= MXI) && (yd <= MYI);
    exp_req = 0;
    if (valid && vc < NVC) begin
      if (head) exp_req = in_range ? (1 << route(xd, yd, yx)) : 0;
      else      exp_req = m_busy[vc] ? (1 << m_port[vc]) : 0;
    end
    bad = (vc >= NVC) || (head ? (m_busy[vc] || !in_range) : !m_busy[vc]);
    exp_err = (valid && ready && bad) ? 1 : 0;
  endtask

  task automatic model_commit(input int exp_err);
    bit head, in_range;
    head = (ftype == 0) || (ftype == 3);
    in_range = (xd <= MXI) && (yd <= MYI);
    if (valid && ready && vc < NVC) begin
      if (head) begin
        if (in_range && ftype == 0) begin m_busy[vc] = 1; m_port[vc] = route(xd, yd, yx); end
        else m_busy[vc] = 0;
      end else if (ftype == 2) m_busy[vc] = 0;
    end
    if (clr) m_cnt = 0;
    else if (exp_err != 0 && m_cnt < CMAX) m_cnt++;
  endtask

  function automatic int busy_vec();
    return {29'b0, m_busy[2], m_busy[1], m_busy[0]};
  endfunction

  vec_t tv[22];

  initial begin
    int er, ee;
    // v r  t  vc x  y  yx clr  req       err busy    cnt
    tv[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 3'b000, 0);
    tv[1]  = mk(1, 1, 0, 0, 3, 1, 0, 0, 5'b00010, 0, 3'b001, 0);
    tv[2]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 5'b00010, 0, 3'b001, 0);
    tv[3]  = mk(1, 1, 2, 0, 0, 0, 0, 0, 5'b00010, 0, 3'b000, 0);
    tv[4]  = mk(1, 1, 3, 0, 0, 2, 1, 0, 5'b01000, 0, 3'b000, 0);
    tv[5]  = mk(1, 1, 3, 0, 1, 1, 1, 0, 5'b10000, 0, 3'b000, 0);
    tv[6]  = mk(1, 1, 0, 1, 1, 0, 0, 0, 5'b00100, 0, 3'b010, 0);
    tv[7]  = mk(1, 1, 0, 2, 0, 1, 0, 0, 5'b00001, 0, 3'b110, 0);
    tv[8]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 5'b00100, 0, 3'b110, 0);
    tv[9]  = mk(1, 1, 1, 2, 0, 0, 0, 0, 5'b00001, 0, 3'b110, 0);
    tv[10] = mk(1, 1, 1, 0, 0, 0, 0, 0, 5'b00000, 1, 3'b110, 1);
    tv[11] = mk(1, 1, 0, 0, 4, 1, 0, 0, 5'b00000, 1, 3'b110, 2);
    tv[12] = mk(1, 1, 0, 1, 1, 3, 0, 0, 5'b01000, 1, 3'b110, 3);
    tv[13] = mk(1, 1, 1, 1, 0, 0, 0, 0, 5'b01000, 0, 3'b110, 3);
    tv[14] = mk(1, 1, 0, 3, 2, 2, 0, 0, 5'b00000, 1, 3'b110, 3);
    tv[15] = mk(1, 1, 2, 2, 0, 0, 0, 0, 5'b00001, 0, 3'b010, 3);
    tv[16] = mk(1, 1, 3, 1, 2, 1, 1, 0, 5'b00010, 1, 3'b000, 3);
    tv[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 3'b000, 0);
    tv[18] = mk(1, 1, 1, 2, 0, 0, 0, 1, 5'b00000, 1, 3'b000, 0);
    tv[19] = mk(1, 1, 0, 0, 3, 3, 1, 0, 5'b01000, 0, 3'b001, 0);
    tv[20] = mk(1, 0, 2, 0, 0, 0, 0, 0, 5'b01000, 0, 3'b001, 0);
    tv[21] = mk(1, 1, 0, 1, 1, 5, 0, 0, 5'b00000, 1, 3'b001, 1);

    #12 arst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_req", req, 0);
    chk("reset_err", err, 0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tv[i].v, tv[i].r, tv[i].t, tv[i].vc, tv[i].x, tv[i].y, tv[i].yx, tv[i].clr);
      #1;
      chk($sformatf("vec%0d_req", i), req, tv[i].req);
      chk($sformatf("vec%0d_err", i), err, tv[i].err);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("vec%0d_cnt", i), cnt, tv[i].cnt);
    end

    // Backpressure: head held for three cycles, commits on the first ready.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 0, 0, 1, 2, 1, 0, 0);
      #1;
      chk("bp_req", req, 5'b00010);
      chk("bp_err", err, 0);
      @(posedge clk); #1;
      chk("bp_busy", busy, 0);
    end
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_commit", busy, 3'b010);

    // Asynchronous reset mid-packet drops the lock; the following body is an error.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    arst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    @(negedge clk);
    arst = 1'b0;
    drive(1, 1, 1, 1, 0, 0, 0, 0);
    #1;
    chk("post_rst_req", req, 0);
    chk("post_rst_err", err, 1);
    @(posedge clk); #1;
    chk("post_rst_cnt", cnt, 1);

    // Saturation, then clear beating a simultaneous increment.
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      drive(1, 1, 1, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("sat_cnt", cnt, (i > CMAX) ? CMAX : i);
    end
    @(negedge clk);
    drive(1, 1, 1, 0, 0, 0, 0, 1);
    #1;
    chk("clr_err", err, 1);
    @(posedge clk); #1;
    chk("clr_cnt", cnt, 0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
      #1;
      model_eval(er, ee);
      chk("rnd_req", req, er);
      chk("rnd_err", err, ee);
      model_commit(ee);
      @(posedge clk); #1;
      chk("rnd_busy", busy, busy_vec());
      chk("rnd_cnt", cnt, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
